rr_arbiter_8: RTL
=================

# rr_arbiter_8

Eight-channel round-robin arbiter that produces the 3-bit channel index driving the `decoder_3_8` select stage. It sits directly upstream of that 3-to-8 decoder, which expands `gnt_idx` into one-hot channel enables. It accepts an 8-bit request vector and issues one registered grant at a time. Each grant is held until the consumer acknowledges it, or until a programmable timeout fires.

## Interface
- `TIMEOUT`, default 15: grant cycles without `ack` before a forced release; 0 disables the timeout.
- `TW`, default 4: width of the wait counter; `TIMEOUT` must be < 2^TW.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 8: request lines; bit i = channel i.
- `ack` in 1: consumer accepts the current grant; sampled only when `gnt_valid`=1.
- `gnt_idx` out 3: granted channel index, fed to the 3-to-8 decoder.
- `gnt_valid` out 1: `gnt_idx` is a live grant.
- `timeout` out 1: one-cycle pulse when a grant is force-released.

## Operation
- Internal state: `ptr` [2:0] (search start), wait counter [TW-1:0], and a two-state FSM (IDLE, GRANT).
- Selection: the first set bit of `req` searched from `ptr` upward, modulo 8 (order ptr, ptr+1, …, 7, 0, …, ptr-1).
- IDLE:
  - `gnt_valid`=0.
  - If `req`≠0, register the selected index into `gnt_idx`, set `gnt_valid`=1, clear the counter and go to GRANT.
  - If `req`=0, stay in IDLE; `gnt_idx` holds its last value.
- GRANT, `ack`=1 (transfer):
  - `ptr` <= `gnt_idx`+1, wrapping 7->0.
  - Re-arbitrate on the same edge using the current `req` and the new `ptr`.
  - If any request is set, go back to back: new `gnt_idx`, `gnt_valid` stays 1, counter cleared.
  - Otherwise go to IDLE with `gnt_valid`=0.
  - A channel that is the only requester is regranted.
- GRANT, `ack`=0, `req[gnt_idx]`=1: the counter increments.
  - When the counter reaches `TIMEOUT`-1 (with `TIMEOUT`≠0), on that edge: `gnt_valid`<=0, `timeout`<=1, `ptr`<=`gnt_idx`+1, go to IDLE.
- GRANT, `ack`=0, `req[gnt_idx]`=0 (request withdrawn): `gnt_valid`<=0, `ptr`<=`gnt_idx`+1, go to IDLE; no `timeout`.
- Simultaneous events:
  - `ack` with the timeout edge: `ack` wins; transfer, no `timeout`.
  - `ack` with withdrawn `req`: counts as a transfer.
- `ack` while `gnt_valid`=0 is ignored.
- `gnt_idx` never changes while `gnt_valid`=1, except on a transfer edge.

## Timing
- Reset values, asserted asynchronously while `rst`=1: `gnt_idx`=0, `gnt_valid`=0, `timeout`=0, `ptr`=0, counter=0, FSM=IDLE.
  - Reset mid-grant drops the grant immediately.
  - The first grant after release follows the normal IDLE rule.
- All outputs are registered; there are no combinational paths from `req` or `ack` to the outputs.
- Latency:
  - `req` sampled at edge k -> `gnt_valid`=1 after edge k.
  - After a transfer with requests pending, the next grant is valid in the following cycle (zero bubbles).
  - After a timeout or withdrawal there is exactly one IDLE cycle before a new grant.
- Timeout: `gnt_valid` is high for exactly `TIMEOUT` cycles, then low for one cycle with `timeout`=1.
- `timeout` is high for exactly one cycle per forced release.
- Fairness: a continuously requesting channel waits at most 7 grants.

## Test plan
- Reset mid-grant:
  - Stimulus: `req`=8'b0000_0100 while in GRANT; raise `rst` between edges.
  - Required: `gnt_valid`, `gnt_idx` and `timeout` go to 0 without waiting for an edge. After release with the same `req`, the grant is `gnt_idx`=2.
- Single requester:
  - Stimulus: `req`=8'b0010_0000.
  - Required: the next cycle shows `gnt_valid`=1, `gnt_idx`=5. `ack` pulsed with `req` held -> `gnt_idx`=5 again with no gap.
- Full load:
  - Stimulus: `req`=8'hFF with `ack`=1 every cycle.
  - Required: `gnt_idx` sequence 0,1,2,3,4,5,6,7,0,1, with `gnt_valid` continuously 1.
- Wrap-around:
  - Stimulus: grant channel 6 and `ack` it (`ptr`=7), then `req`=8'b0100_0001.
  - Required: grant 0 next; after `ack`, grant 6.
- Timeout with `TIMEOUT`=4:
  - Stimulus: `req`=8'b0000_1000, `ack`=0.
  - Required: `gnt_valid`=1 for 4 cycles (`gnt_idx`=3), then 1 cycle with `gnt_valid`=0 and `timeout`=1, then a regrant of 3.
- Ack on the timeout edge with `TIMEOUT`=4:
  - Stimulus: `ack`=1 on the 4th grant cycle.
  - Required: `timeout` stays 0; the transfer proceeds and channel 3 is regranted back to back.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Eight-channel round-robin arbiter with acknowledge/timeout-driven release.
// Produces a registered 3-bit channel index for the downstream 3-to-8 decoder.
module rr_arbiter_8 #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          vld_q, vld_d;
  logic          to_q, to_d;

  logic [2:0]    ptr_next;
  logic [3:0]    pick_idle;
  logic [3:0]    pick_xfer;

  // Returns {found, index}: first set bit of r starting at p, wrapping modulo 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] c;
    res = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      c = p + 3'(i);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign ptr_next  = idx_q + 3'd1;
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_xfer = rr_pick(req, ptr_next);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        vld_d = 1'b0;
        if (pick_idle[3]) begin
          idx_d   = pick_idle[2:0];
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Ack takes priority over both withdrawal and timeout.
        if (ack) begin
          ptr_d = ptr_next;
          if (pick_xfer[3]) begin
            idx_d = pick_xfer[2:0];
            vld_d = 1'b1;
            cnt_d = '0;
          end else begin
            vld_d   = 1'b0;
            state_d = S_IDLE;
          end
        end else if (!req[idx_q]) begin
          ptr_d   = ptr_next;
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          ptr_d   = ptr_next;
          vld_d   = 1'b0;
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
  assign timeout   = to_q;

endmodule
